// File: rtl/fft_twiddle_gen_pkg.sv
// Shared FFT package: constants and helpers used by the twiddle generator
// and its quarter-wave table.
//   twiddle_amp   : full-scale amplitude 2^(w-1)-1 (+1.0 saturated)
//   quarter_depth : quarter-wave table depth FFT_N/4
//   digit_rev     : radix-2^2 digit-reversed multiplier map 0->0,1->2,2->1,3->3
package fft_twiddle_gen_pkg;

  function automatic int twiddle_amp(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int quarter_depth(input int fft_n);
    return fft_n / 4;
  endfunction

  // Swapping the two bits of q gives exactly the 0,2,1,3 ordering.
  function automatic logic [1:0] digit_rev(input logic [1:0] q);
    return {q[0], q[1]};
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Quarter-wave cosine table C(k) = round(A*cos(2*pi*k/FFT_N)), k = 0..FFT_N/4-1,
// with two independent registered read ports.
// Contents are computed at elaboration and never reset.
//   clk_i  : clock
//   addr_a : read address, port A
//   addr_b : read address, port B
//   data_a : registered C(addr_a)
//   data_b : registered C(addr_b)
module fft_twiddle_rom
  import fft_twiddle_gen_pkg::*;
#(
  parameter int TWIDDLE_WIDTH = 10,
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10
) (
  input  logic                            clk_i,
  input  logic        [NLOG2-3:0]         addr_a,
  input  logic        [NLOG2-3:0]         addr_b,
  output logic signed [TWIDDLE_WIDTH-1:0] data_a,
  output logic signed [TWIDDLE_WIDTH-1:0] data_b
);

  localparam int  DEPTH = quarter_depth(FFT_N);
  localparam int  AMP   = twiddle_amp(TWIDDLE_WIDTH);
  localparam real PI    = 3.14159265358979323846;

  // All entries lie in the first quadrant, so the cosine is non-negative
  // and add-half-then-truncate is round-to-nearest.
  function automatic logic signed [TWIDDLE_WIDTH-1:0] cos_entry(input int k);
    real v;
    v = real'(AMP) * $cos(2.0 * PI * real'(k) / real'(FFT_N));
    return TWIDDLE_WIDTH'($rtoi(v + 0.5));
  endfunction

  logic signed [TWIDDLE_WIDTH-1:0] tab [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    assign tab[k] = cos_entry(k);
  end

  always_ff @(posedge clk_i) begin
    data_a <= tab[addr_a];
    data_b <= tab[addr_b];
  end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Twiddle factor generator for a radix-2^2 SDF FFT stage.
// For sample index ctr_i it produces W = exp(-j*2*pi*e/FFT_N), where
// e = m*r mod FFT_N, m is the digit-reversed top two bits of ctr_i and r
// the remaining bits. Fixed 3-cycle latency, one sample per cycle.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (control and outputs)
//   en_i    : ctr_i valid this cycle
//   ctr_i   : sample index within the frame
//   valid_o : outputs valid
//   ctr_o   : ctr_i aligned with the twiddle
//   w_re_o  : twiddle real part, signed
//   w_im_o  : twiddle imaginary part, signed
module fft_twiddle_gen
  import fft_twiddle_gen_pkg::*;
#(
  parameter int TWIDDLE_WIDTH = 10,
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic        [NLOG2-1:0]         ctr_i,
  output logic                            valid_o,
  output logic        [NLOG2-1:0]         ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

  localparam int RW = NLOG2 - 2;

  // Two's-complement negate; the most negative code maps to +full-scale.
  // Table values never reach that code, so this only guards the edge.
  function automatic logic signed [TWIDDLE_WIDTH-1:0] neg_sat(
    input logic signed [TWIDDLE_WIDTH-1:0] x
  );
    if (x == {1'b1, {(TWIDDLE_WIDTH-1){1'b0}}})
      return {1'b0, {(TWIDDLE_WIDTH-1){1'b1}}};
    return -x;
  endfunction

  logic [1:0]       q;
  logic [1:0]       m;
  logic [RW-1:0]    r;
  logic [NLOG2-1:0] r_ext;
  logic [NLOG2-1:0] e_next;

  assign q     = ctr_i[NLOG2-1 -: 2];
  assign r     = ctr_i[RW-1:0];
  assign m     = digit_rev(q);
  assign r_ext = {2'b00, r};

  // m*r with m in 0..3 needs only shifts and one add; the NLOG2-bit
  // result is already reduced mod FFT_N.
  always_comb begin
    e_next = '0;
    case (m)
      2'd0:    e_next = '0;
      2'd1:    e_next = r_ext;
      2'd2:    e_next = r_ext << 1;
      default: e_next = r_ext + (r_ext << 1);
    endcase
  end

  // ---- Stage 1: exponent register ----
  logic             vld_p0;
  logic [NLOG2-1:0] e_p0;
  logic [NLOG2-1:0] ctr_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p0 <= 1'b0;
    else       vld_p0 <= en_i;
    e_p0   <= e_next;
    ctr_p0 <= ctr_i;
  end

  logic [1:0]    d_p0;
  logic [RW-1:0] i_p0;
  logic [RW-1:0] s_addr_p0;

  assign d_p0      = e_p0[NLOG2-1 -: 2];
  assign i_p0      = e_p0[RW-1:0];
  // FFT_N/4 - i modulo the table depth; i = 0 wraps to 0 and is zeroed later.
  assign s_addr_p0 = -i_p0;

  // ---- Stage 2: registered table read ----
  logic                            vld_p1;
  logic        [1:0]               d_p1;
  logic                            izero_p1;
  logic        [NLOG2-1:0]         ctr_p1;
  logic signed [TWIDDLE_WIDTH-1:0] c_p1;
  logic signed [TWIDDLE_WIDTH-1:0] s_raw_p1;

  fft_twiddle_rom #(
    .TWIDDLE_WIDTH (TWIDDLE_WIDTH),
    .FFT_N         (FFT_N),
    .NLOG2         (NLOG2)
  ) u_rom (
    .clk_i  (clk_i),
    .addr_a (i_p0),
    .addr_b (s_addr_p0),
    .data_a (c_p1),
    .data_b (s_raw_p1)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
    d_p1     <= d_p0;
    izero_p1 <= (i_p0 == '0);
    ctr_p1   <= ctr_p0;
  end

  logic signed [TWIDDLE_WIDTH-1:0] s_p1;
  logic signed [TWIDDLE_WIDTH-1:0] re_p1;
  logic signed [TWIDDLE_WIDTH-1:0] im_p1;

  always_comb begin
    s_p1  = izero_p1 ? '0 : s_raw_p1;
    re_p1 = c_p1;
    im_p1 = neg_sat(s_p1);
    case (d_p1)
      2'd0: begin re_p1 = c_p1;          im_p1 = neg_sat(s_p1); end
      2'd1: begin re_p1 = neg_sat(s_p1); im_p1 = neg_sat(c_p1); end
      2'd2: begin re_p1 = neg_sat(c_p1); im_p1 = s_p1;          end
      default: begin re_p1 = s_p1;       im_p1 = c_p1;          end
    endcase
  end

  // ---- Stage 3: quadrant fold and output register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      ctr_o   <= '0;
      w_re_o  <= '0;
      w_im_o  <= '0;
    end else begin
      valid_o <= vld_p1;
      if (vld_p1) begin
        ctr_o  <= ctr_p1;
        w_re_o <= re_p1;
        w_im_o <= im_p1;
      end
    end
  end

endmodule
